// File: rtl/dec_key_schedule_128.sv
// SWAN64 decryption key schedule (128-bit key): runs the encryption schedule forward, then walks it back emitting sk_R..sk_1.
// Latency: start accepted at edge t -> first subkey valid after edge t+ROUNDS; one subkey per cycle under continuous ready.
// Backpressure: sk/sk_round are registered and hold while sk_valid && !sk_ready; no combinational path from sk_ready.
module dec_key_schedule_128 #(
  parameter int          BLOCK_SIZE = 64,
  parameter int          SIDE_SIZE  = BLOCK_SIZE / 2,
  parameter int          KEY_SIZE   = 128,
  parameter int          PD         = 24,
  parameter logic [31:0] DELTA0     = 32'h9e3779b9,
  parameter int          ROUNDS     = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [0:KEY_SIZE-1]   key_in,
  output logic                  busy,
  output logic                  sk_valid,
  input  logic                  sk_ready,
  output logic [0:SIDE_SIZE-1]  sk,
  output logic [5:0]            sk_round,
  output logic                  done
);

  // Subkey lives in the least-significant side word (bits SK_LO..KEY_SIZE-1, bit 0 = MSB).
  localparam int          SK_LO    = KEY_SIZE - SIDE_SIZE;
  localparam logic [5:0]  ROUNDS_W = 6'(ROUNDS);
  localparam logic [5:0]  LAST_FWD = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t                 state;
  logic [0:KEY_SIZE-1]    key_reg;
  logic [SIDE_SIZE-1:0]   delta_reg;
  logic [5:0]             cnt;

  logic [0:KEY_SIZE-1]    rot_r;
  logic [0:KEY_SIZE-1]    k_fwd;
  logic [0:KEY_SIZE-1]    r_inv;
  logic [0:KEY_SIZE-1]    k_inv;
  logic [SIDE_SIZE-1:0]   d_fwd;
  logic [SIDE_SIZE-1:0]   s_fwd;
  logic [SIDE_SIZE-1:0]   d_inv;
  logic [SIDE_SIZE-1:0]   s_inv;

  // Forward (encryption) step and its exact inverse, both computed from the current state.
  always_comb begin
    rot_r = {key_reg[KEY_SIZE-PD:KEY_SIZE-1], key_reg[0:KEY_SIZE-PD-1]};
    d_fwd = delta_reg + DELTA0;
    s_fwd = rot_r[SK_LO:KEY_SIZE-1] + d_fwd;
    k_fwd = {rot_r[0:SK_LO-1], s_fwd};

    s_inv = key_reg[SK_LO:KEY_SIZE-1] - delta_reg;
    r_inv = {key_reg[0:SK_LO-1], s_inv};
    k_inv = {r_inv[PD:KEY_SIZE-1], r_inv[0:PD-1]};
    d_inv = delta_reg - DELTA0;
  end

  // Control FSM with registered outputs; sk is loaded with the next subkey whenever EMIT is (re)entered or advanced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      delta_reg <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      sk_valid  <= 1'b0;
      sk        <= '0;
      sk_round  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_reg   <= key_in;
            delta_reg <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= FWD;
          end
        end
        FWD: begin
          key_reg   <= k_fwd;
          delta_reg <= d_fwd;
          cnt       <= cnt + 6'd1;
          if (cnt == LAST_FWD) begin
            state    <= EMIT;
            sk_valid <= 1'b1;
            sk       <= k_fwd[SK_LO:KEY_SIZE-1];
            sk_round <= ROUNDS_W;
          end
        end
        EMIT: begin
          if (sk_ready) begin
            key_reg   <= k_inv;
            delta_reg <= d_inv;
            cnt       <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              // Last subkey taken: key_reg/delta_reg are back at key_in/0; sk keeps its last value.
              state    <= IDLE;
              sk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              sk       <= k_inv[SK_LO:KEY_SIZE-1];
              sk_round <= cnt - 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_key_schedule_128.sv
module tb_dec_key_schedule_128;

  localparam logic [31:0] DLT = 32'h9e3779b9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ROUNDS = 48 instance
  logic         start_a = 1'b0, rdy_a = 1'b0;
  logic [127:0] key_a = '0;
  logic         busy_a, vld_a, done_a;
  logic [31:0]  sk_a;
  logic [5:0]   rnd_a;
  // ROUNDS = 1 instance
  logic         start_b = 1'b0, rdy_b = 1'b0;
  logic [127:0] key_b = '0;
  logic         busy_b, vld_b, done_b;
  logic [31:0]  sk_b;
  logic [5:0]   rnd_b;
  // ROUNDS = 2 instance
  logic         start_c = 1'b0, rdy_c = 1'b0;
  logic [127:0] key_c = '0;
  logic         busy_c, vld_c, done_c;
  logic [31:0]  sk_c;
  logic [5:0]   rnd_c;

  dec_key_schedule_128 #(.ROUNDS(48)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .key_in(key_a), .busy(busy_a),
    .sk_valid(vld_a), .sk_ready(rdy_a), .sk(sk_a), .sk_round(rnd_a), .done(done_a));
  dec_key_schedule_128 #(.ROUNDS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .key_in(key_b), .busy(busy_b),
    .sk_valid(vld_b), .sk_ready(rdy_b), .sk(sk_b), .sk_round(rnd_b), .done(done_b));
  dec_key_schedule_128 #(.ROUNDS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .key_in(key_c), .busy(busy_c),
    .sk_valid(vld_c), .sk_ready(rdy_c), .sk(sk_c), .sk_round(rnd_c), .done(done_c));

  typedef struct {
    logic [5:0]  rnd;
    logic [31:0] sk;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference encryption schedule: numeric view, MSB of the 128-bit word is key bit 0.
  task automatic push_expected(input logic [127:0] key);
    logic [127:0] k;
    logic [127:0] r;
    logic [31:0]  d;
    logic [31:0]  ref_sk [1:48];
    k = key;
    d = '0;
    for (int i = 1; i <= 48; i++) begin
      r = (k >> 24) | (k << 104);
      d = d + DLT;
      r[31:0] = r[31:0] + d;
      k = r;
      ref_sk[i] = k[31:0];
    end
    for (int i = 48; i >= 1; i--) sb.push_back('{rnd: 6'(i), sk: ref_sk[i]});
  endtask

  // Issue start on dut_a and check first-valid latency; optionally pokes start during FWD.
  task automatic start_a_run(input logic [127:0] key, input bit poke);
    int n;
    push_expected(key);
    @(negedge clk);
    key_a = key;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    total++;
    if (busy_a !== 1'b1 || vld_a !== 1'b0) begin
      bad++;
      $display("FAIL fwd_entry: busy=%b valid=%b, required busy=1 valid=0", busy_a, vld_a);
    end
    n = 1;
    while (!vld_a && n < 300) begin
      start_a = (poke && n == 5);
      @(negedge clk);
      n++;
    end
    start_a = 1'b0;
    total++;
    if (n !== 49) begin
      bad++;
      $display("FAIL latency48: first valid after %0d edges, required 49", n);
    end
  endtask

  // Consume n subkeys from dut_a against the scoreboard with pct% ready duty.
  task automatic drain_a(input int n, input int pct, input bit poke);
    int          got;
    int          guard;
    bit          held;
    bit          r;
    logic [31:0] h_sk;
    logic [5:0]  h_rnd;
    exp_t        e;
    got = 0;
    guard = 0;
    held = 1'b0;
    h_sk = '0;
    h_rnd = '0;
    while (got < n && guard < 3000) begin
      if (held) begin
        total++;
        if (sk_a !== h_sk || rnd_a !== h_rnd || vld_a !== 1'b1) begin
          bad++;
          $display("FAIL hold_stable: sk=%h rnd=%0d vld=%b, required sk=%h rnd=%0d vld=1",
                   sk_a, rnd_a, vld_a, h_sk, h_rnd);
        end
      end
      r = ($urandom_range(99) < pct);
      rdy_a = r;
      start_a = (poke && got == 3);
      held = 1'b0;
      if (vld_a) begin
        if (r) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL extra_subkey: sk=%h rnd=%0d, required none", sk_a, rnd_a);
          end else begin
            e = sb.pop_front();
            if (sk_a !== e.sk || rnd_a !== e.rnd) begin
              bad++;
              $display("FAIL subkey: sk=%h rnd=%0d, required sk=%h rnd=%0d", sk_a, rnd_a, e.sk, e.rnd);
            end
          end
          got++;
        end else begin
          held = 1'b1;
          h_sk = sk_a;
          h_rnd = rnd_a;
        end
      end
      @(negedge clk);
      guard++;
    end
    rdy_a = 1'b0;
    start_a = 1'b0;
    total++;
    if (got !== n) begin
      bad++;
      $display("FAIL drain_count: got %0d subkeys, required %0d", got, n);
    end
  endtask

  // After the 48th transfer edge: done pulse, idle outputs, restored key state.
  task automatic check_end_a(input logic [127:0] key);
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || vld_a !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL end48: done=%b busy=%b vld=%b left=%0d, required 1 0 0 0", done_a, busy_a, vld_a, sb.size());
    end
    @(negedge clk);
    total++;
    if (done_a !== 1'b0 || dut_a.key_reg !== key || dut_a.delta_reg !== 32'h0) begin
      bad++;
      $display("FAIL restore48: done=%b key_reg=%h delta=%h, required done=0 key=%h delta=0",
               done_a, dut_a.key_reg, dut_a.delta_reg, key);
    end
    sb.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy_a, vld_a, done_a, sk_a, rnd_a, busy_b, vld_b, done_b, sk_b, rnd_b,
         busy_c, vld_c, done_c, sk_c, rnd_c} !== '0 || dut_a.key_reg !== '0 || dut_a.cnt !== '0) begin
      bad++;
      $display("FAIL reset: outputs a=%b%b%b %h %0d, required all zero", busy_a, vld_a, done_a, sk_a, rnd_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rounds1;
    int n;
    @(negedge clk);
    key_b = '0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 1;
    while (!vld_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 2 || sk_b !== DLT || rnd_b !== 6'd1) begin
      bad++;
      $display("FAIL rounds1_first: edges=%0d sk=%h rnd=%0d, required 2 %h 1", n, sk_b, rnd_b, DLT);
    end
    rdy_b = 1'b1;
    @(negedge clk);
    rdy_b = 1'b0;
    total++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || vld_b !== 1'b0 || sk_b !== DLT) begin
      bad++;
      $display("FAIL rounds1_done: done=%b busy=%b vld=%b sk=%h, required 1 0 0 %h", done_b, busy_b, vld_b, sk_b, DLT);
    end
    @(negedge clk);
    total++;
    if (done_b !== 1'b0) begin
      bad++;
      $display("FAIL rounds1_pulse: done=%b, required 0", done_b);
    end
  endtask

  // start held high through done re-triggers a load right after the done cycle.
  task automatic test_retrigger;
    int n;
    @(negedge clk);
    key_b = '0;
    start_b = 1'b1;
    rdy_b = 1'b1;
    n = 0;
    while (!done_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (busy_b !== 1'b1 || done_b !== 1'b0) begin
      bad++;
      $display("FAIL retrigger: busy=%b done=%b, required busy=1 done=0", busy_b, done_b);
    end
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    rdy_b = 1'b0;
    @(negedge clk);
    total++;
    if (busy_b !== 1'b0 || vld_b !== 1'b0) begin
      bad++;
      $display("FAIL retrigger_idle: busy=%b vld=%b, required 0 0", busy_b, vld_b);
    end
  endtask

  // ROUNDS=2 with ready already high during FWD (no effect outside EMIT).
  task automatic test_rounds2;
    int n;
    @(negedge clk);
    key_c = '0;
    rdy_c = 1'b1;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    n = 1;
    while (!vld_c && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 3 || sk_c !== 32'h3c6ef410 || rnd_c !== 6'd2) begin
      bad++;
      $display("FAIL rounds2_sk2: edges=%0d sk=%h rnd=%0d, required 3 3c6ef410 2", n, sk_c, rnd_c);
    end
    @(negedge clk);
    total++;
    if (vld_c !== 1'b1 || sk_c !== DLT || rnd_c !== 6'd1) begin
      bad++;
      $display("FAIL rounds2_sk1: vld=%b sk=%h rnd=%0d, required 1 %h 1", vld_c, sk_c, rnd_c, DLT);
    end
    @(negedge clk);
    rdy_c = 1'b0;
    total++;
    if (done_c !== 1'b1 || vld_c !== 1'b0) begin
      bad++;
      $display("FAIL rounds2_done: done=%b vld=%b, required 1 0", done_c, vld_c);
    end
  endtask

  task automatic test_random_keys;
    logic [127:0] k;
    for (int i = 0; i < 100; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      start_a_run(k, 1'b0);
      drain_a(48, 100, 1'b0);
      check_end_a(k);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] k;
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      start_a_run(k, 1'b0);
      drain_a(48, 30, 1'b0);
      check_end_a(k);
    end
  endtask

  task automatic test_start_ignored;
    logic [127:0] k;
    k = 128'hdeadbeef_00112233_cafef00d_55aa55aa;
    start_a_run(k, 1'b1);
    drain_a(48, 60, 1'b1);
    check_end_a(k);
  endtask

  task automatic test_reset_mid_emit;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    start_a_run(k, 1'b0);
    drain_a(10, 100, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy_a, vld_a, done_a, sk_a, rnd_a} !== '0 || dut_a.key_reg !== '0 || dut_a.delta_reg !== '0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b vld=%b done=%b sk=%h rnd=%0d, required all zero",
               busy_a, vld_a, done_a, sk_a, rnd_a);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b vld=%b, required 0 0", busy_a, vld_a);
    end
    k = 128'h0123456789abcdeffedcba9876543210;
    start_a_run(k, 1'b0);
    drain_a(48, 100, 1'b0);
    check_end_a(k);
  endtask

  initial begin
    test_reset();
    test_rounds1();
    test_retrigger();
    test_rounds2();
    test_random_keys();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
